// File: rtl/e603_mrom_arb_defs.sv
// rtl/e603_mrom_arb_defs.sv - shared state encoding and helpers for the MROM ICB arbiter
package e603_mrom_arb_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RSP_M0 = 2'd1,
    RSP_M1 = 2'd2
  } arb_state_e;

  function automatic logic word_in_range(input logic [31:0] idx, input logic [31:0] depth);
    return idx < depth;
  endfunction

endpackage

// File: rtl/e603_rr_arb2.sv
// rtl/e603_rr_arb2.sv - two-requester round-robin picker with its own last-grant flop
module e603_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  output logic gnt0,
  output logic gnt1
);

  // 1 means requester 1 won most recently, so requester 0 wins the next tie
  logic last_grant;

  always_comb begin
    gnt0 = req0 & (~req1 | last_grant);
    gnt1 = req1 & (~req0 | ~last_grant);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (upd) begin
      last_grant <= gnt1;
    end
  end

endmodule

// File: rtl/e603_mrom_icb_arb.sv
// rtl/e603_mrom_icb_arb.sv - two-master ICB arbiter with a shared one-entry MROM response buffer
module e603_mrom_icb_arb
  import e603_mrom_arb_defs::*;
#(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int DP = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic [AW-1:0] m0_icb_cmd_addr,
  input  logic          m0_icb_cmd_read,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic          m0_icb_rsp_err,
  output logic [DW-1:0] m0_icb_rsp_rdata,
  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic [AW-1:0] m1_icb_cmd_addr,
  input  logic          m1_icb_cmd_read,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic          m1_icb_rsp_err,
  output logic [DW-1:0] m1_icb_rsp_rdata,
  output logic [AW-3:0] rom_addr,
  input  logic [DW-1:0] rom_dout
);

  arb_state_e    state;
  logic          err_q;
  logic [DW-1:0] rdata_q;
  logic [AW-3:0] addr_hold;
  logic          gnt0, gnt1, sel0, sel1;
  logic          free, accept, cmd_read, in_range;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^{m0_icb_cmd_addr[1:0], m1_icb_cmd_addr[1:0]};

  e603_rr_arb2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .req0 (m0_icb_cmd_valid),
    .req1 (m1_icb_cmd_valid),
    .upd  (accept),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // The buffer frees up in the same cycle its owner consumes the response
  assign free = (state == IDLE)
              | ((state == RSP_M0) & m0_icb_rsp_ready)
              | ((state == RSP_M1) & m1_icb_rsp_ready);

  assign sel0   = ~rst & gnt0;
  assign sel1   = ~rst & gnt1;
  assign accept = free & (sel0 | sel1);

  assign m0_icb_cmd_ready = free & sel0;
  assign m1_icb_cmd_ready = free & sel1;

  // Hold the last driven word address so the ROM input never sees the losing master
  assign rom_addr = sel0 ? m0_icb_cmd_addr[AW-1:2] :
                    sel1 ? m1_icb_cmd_addr[AW-1:2] : addr_hold;
  assign cmd_read = sel0 ? m0_icb_cmd_read : m1_icb_cmd_read;
  assign in_range = word_in_range(32'(rom_addr), 32'(DP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      addr_hold <= '0;
    end else begin
      addr_hold <= rom_addr;
      if (accept) begin
        state <= sel0 ? RSP_M0 : RSP_M1;
        if (cmd_read & in_range) begin
          err_q   <= 1'b0;
          rdata_q <= rom_dout;
        end else begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end else if (free) begin
        state <= IDLE;
      end
    end
  end

  assign m0_icb_rsp_valid = (state == RSP_M0);
  assign m1_icb_rsp_valid = (state == RSP_M1);
  assign m0_icb_rsp_err   = m0_icb_rsp_valid & err_q;
  assign m1_icb_rsp_err   = m1_icb_rsp_valid & err_q;
  assign m0_icb_rsp_rdata = m0_icb_rsp_valid ? rdata_q : '0;
  assign m1_icb_rsp_rdata = m1_icb_rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_e603_mrom_icb_arb.sv
// tb/tb_e603_mrom_icb_arb.sv - randomized self-checking bench for e603_mrom_icb_arb
module tb_e603_mrom_icb_arb;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int DP = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_v, m0_rdy, m0_rd, m0_rv, m0_rr, m0_err;
  logic          m1_v, m1_rdy, m1_rd, m1_rv, m1_rr, m1_err;
  logic [AW-1:0] m0_a, m1_a;
  logic [DW-1:0] m0_rdata, m1_rdata, rom_dout;
  logic [AW-3:0] rom_addr;

  logic [31:0] mem [0:DP-1];

  always_comb rom_dout = (int'(rom_addr) < DP) ? mem[int'(rom_addr)] : 32'hBAD0BAD0;

  e603_mrom_icb_arb #(.AW(AW), .DW(DW), .DP(DP)) dut (
    .clk              (clk),
    .rst              (rst),
    .m0_icb_cmd_valid (m0_v),
    .m0_icb_cmd_ready (m0_rdy),
    .m0_icb_cmd_addr  (m0_a),
    .m0_icb_cmd_read  (m0_rd),
    .m0_icb_rsp_valid (m0_rv),
    .m0_icb_rsp_ready (m0_rr),
    .m0_icb_rsp_err   (m0_err),
    .m0_icb_rsp_rdata (m0_rdata),
    .m1_icb_cmd_valid (m1_v),
    .m1_icb_cmd_ready (m1_rdy),
    .m1_icb_cmd_addr  (m1_a),
    .m1_icb_cmd_read  (m1_rd),
    .m1_icb_rsp_valid (m1_rv),
    .m1_icb_rsp_ready (m1_rr),
    .m1_icb_rsp_err   (m1_err),
    .m1_icb_rsp_rdata (m1_rdata),
    .rom_addr         (rom_addr),
    .rom_dout         (rom_dout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: who owns the pending response (0 none, 1 m0, 2 m1), its contents, last winner
  int          own = 0;
  int          last = 1;
  int          last_win = -1;
  logic        exp_err = 1'b0;
  logic [31:0] exp_rdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int          win;
    int          idx;
    logic        free;
    logic [AW-1:0] a;
    logic        rd;
    @(negedge clk);
    check("m0_rsp_valid", m0_rv, own == 1);
    check("m1_rsp_valid", m1_rv, own == 2);
    check("m0_rsp_err",   m0_err, (own == 1) ? exp_err : 1'b0);
    check("m1_rsp_err",   m1_err, (own == 2) ? exp_err : 1'b0);
    check("m0_rsp_rdata", m0_rdata, (own == 1) ? exp_rdata : 32'h0);
    check("m1_rsp_rdata", m1_rdata, (own == 2) ? exp_rdata : 32'h0);
    free = (own == 0) || (own == 1 && m0_rr) || (own == 2 && m1_rr);
    win = -1;
    if (m0_v && m1_v) win = (last == 1) ? 0 : 1;
    else if (m0_v)    win = 0;
    else if (m1_v)    win = 1;
    if (rst) begin
      check("m0_cmd_ready_rst", m0_rdy, 1'b0);
      check("m1_cmd_ready_rst", m1_rdy, 1'b0);
      own = 0; last = 1; exp_err = 1'b0; exp_rdata = '0; last_win = -1;
    end else begin
      check("m0_cmd_ready", m0_rdy, free && win == 0);
      check("m1_cmd_ready", m1_rdy, free && win == 1);
      last_win = free ? win : -1;
      if (free && win >= 0) begin
        a   = (win == 1) ? m1_a : m0_a;
        rd  = (win == 1) ? m1_rd : m0_rd;
        idx = int'(a) / 4;
        check("rom_addr", rom_addr, a[AW-1:2]);
        if (rd && idx < DP) begin
          exp_err = 1'b0; exp_rdata = mem[idx];
        end else begin
          exp_err = 1'b1; exp_rdata = '0;
        end
        own = win + 1;
        last = win;
      end else if (free) begin
        own = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_v = 0; m1_v = 0; m0_rd = 1; m1_rd = 1; m0_a = '0; m1_a = '0; m0_rr = 1; m1_rr = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    step();
    step();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_m0_valid", m0_rv, 1'b0);
    check("rst_m1_valid", m1_rv, 1'b0);
    check("rst_m0_rdata", m0_rdata, 0);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    for (int i = 0; i < DP; i++) mem[i] = $urandom;
    mem[1] = 32'hDEADBEEF;
    do_reset();

    // single read by m0
    m0_v = 1; m0_a = 13'h004; step(); m0_v = 0;
    check("single_grant", last_win, 0);
    check("single_rdata", m0_rdata, 32'hDEADBEEF);
    check("single_err", m0_err, 1'b0);
    check("single_m1_valid", m1_rv, 1'b0);
    step();

    // simultaneous after reset: m0 first, then m1
    do_reset();
    m0_v = 1; m0_a = 13'h008; m1_v = 1; m1_a = 13'h00C;
    step();
    check("tie_first", last_win, 0);
    check("tie_m0_rdata", m0_rdata, mem[2]);
    m0_v = 0;
    step();
    check("tie_second", last_win, 1);
    check("tie_m1_rdata", m1_rdata, mem[3]);
    m1_v = 0;
    step();

    // continuous contention alternates starting from m0
    do_reset();
    m0_v = 1; m1_v = 1; m0_a = 13'h020; m1_a = 13'h024;
    for (int i = 0; i < 6; i++) begin
      step();
      check("contention_grant", last_win, i % 2);
    end
    m0_v = 0; m1_v = 0;
    step();

    // write and out-of-range
    m1_v = 1; m1_a = 13'h010; m1_rd = 0; step(); m1_v = 0; m1_rd = 1;
    check("write_err", m1_err, 1'b1);
    check("write_rdata", m1_rdata, 0);
    m0_v = 1; m0_a = 13'h1000; step(); m0_v = 0;
    check("oor_err", m0_err, 1'b1);
    check("oor_rdata", m0_rdata, 0);
    step();

    // backpressure from m0 blocks m1
    m0_v = 1; m0_a = 13'h014; step(); m0_v = 0; m0_rr = 0;
    m1_v = 1; m1_a = 13'h018;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_m0_rdata", m0_rdata, mem[5]);
      check("bp_no_grant", last_win, -1);
    end
    m0_rr = 1;
    step();
    check("bp_release_grant", last_win, 1);
    m1_v = 0;
    check("bp_m1_rdata", m1_rdata, mem[6]);

    // reset with a pending response
    m0_v = 1; m0_a = 13'h01C; step(); m0_v = 0; m0_rr = 0;
    rst = 1; step(); rst = 0; m0_rr = 1;
    check("rst_drop_valid", m0_rv, 1'b0);
    m0_v = 1; m1_v = 1; m0_a = 13'h028; m1_a = 13'h02C;
    step();
    check("rst_tie_m0", last_win, 0);
    idle_inputs();
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      m0_v  = ($urandom_range(0, 3) != 0);
      m1_v  = ($urandom_range(0, 3) != 0);
      m0_a  = AW'($urandom_range(0, 8191));
      m1_a  = AW'($urandom_range(0, 8191));
      m0_rd = ($urandom_range(0, 9) != 0);
      m1_rd = ($urandom_range(0, 9) != 0);
      m0_rr = ($urandom_range(0, 3) != 0);
      m1_rr = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0;
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
